// File: rtl/fac_pkg.sv
// Shared definitions for the factorial datapath: state encoding and widths.
package fac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fac_mul_state_t;

    localparam int unsigned FAC_WIDTH      = 64;
    localparam int unsigned FAC_MUL_CYCLES = FAC_WIDTH / 2;
    localparam int unsigned FAC_CNT_W      = $clog2(FAC_MUL_CYCLES);
    localparam int unsigned FAC_PROD_W     = 2 * FAC_WIDTH;
    localparam int unsigned FAC_ACC_W      = 2 * FAC_WIDTH + 2;

endpackage

// File: rtl/fac_mul_r4_if.sv
// Controller <-> multiplier handshake: operands, start/clear, done/busy and product.
interface fac_mul_r4_if
    import fac_pkg::*;
#(
    parameter int unsigned WIDTH = FAC_WIDTH
) ();

    logic [WIDTH-1:0]   multi;
    logic [WIDTH-1:0]   multiplicand;
    logic               op_start;
    logic               op_clear;
    logic               op_done;
    logic               busy;
    logic [2*WIDTH-1:0] result;

    modport master (
        output multi, multiplicand, op_start, op_clear,
        input  op_done, busy, result
    );

    modport slave (
        input  multi, multiplicand, op_start, op_clear,
        output op_done, busy, result
    );

endinterface

// File: rtl/fac_mul_pp_sel.sv
// Radix-4 partial-product select: picks 0, M, 2M or 3M from two multiplier bits.
module fac_mul_pp_sel #(
    parameter int unsigned ACC_W = 130
) (
    input  logic [1:0]       sel,
    input  logic [ACC_W-1:0] m1,
    input  logic [ACC_W-1:0] m2,
    input  logic [ACC_W-1:0] m3,
    output logic [ACC_W-1:0] pp_c
);

    always_comb begin
        pp_c = '0;
        unique case (sel)
            2'd0: pp_c = '0;
            2'd1: pp_c = m1;
            2'd2: pp_c = m2;
            2'd3: pp_c = m3;
            default: pp_c = '0;
        endcase
    end

endmodule

// File: rtl/fac_mul_r4.sv
// Sequential unsigned WIDTH x WIDTH multiplier, two multiplier bits retired per cycle.
module fac_mul_r4
    import fac_pkg::*;
#(
    parameter int unsigned WIDTH = FAC_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    fac_mul_r4_if.slave   bus
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = 2 * WIDTH + 2;
    localparam int unsigned CYCLES = WIDTH / 2;
    localparam int unsigned CNT_W  = $clog2(CYCLES);

    fac_mul_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [ACC_W-1:0]   m_q, m_d;
    logic [ACC_W-1:0]   m3_q, m3_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]  result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [ACC_W-1:0]   m2;
    logic [ACC_W-1:0]   pp_c;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   mc_ext;

    assign m2      = m_q << 1;
    assign mc_ext  = ACC_W'(bus.multiplicand);
    assign acc_sum = acc_q + (pp_c << {cnt_q, 1'b0});

    fac_mul_pp_sel #(.ACC_W(ACC_W)) u_pp_sel (
        .sel  (q_q[1:0]),
        .m1   (m_q),
        .m2   (m2),
        .m3   (m3_q),
        .pp_c (pp_c)
    );

    // Next-state and datapath update; clear overrides every state action.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        m_d      = m_q;
        m3_d     = m3_q;
        acc_d    = acc_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (bus.op_start) begin
                    m_d  = mc_ext;
                    m3_d = mc_ext + (mc_ext << 1);
                    q_d  = bus.multi;
                    if ((bus.multi == '0) || (bus.multiplicand == '0)) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_d = acc_sum;
                q_d   = q_q >> 2;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CYCLES - 1)) begin
                    result_d = acc_sum[PROD_W-1:0];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.op_clear) begin
            state_d  = IDLE;
            result_d = '0;
            cnt_d    = '0;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d == EXEC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            m3_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            m_q      <= m_d;
            m3_q     <= m3_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.op_done = done_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_fac_mul_r4.sv
// Directed bench for fac_mul_r4: latency, zero shortcut, clear/reset behaviour, 20! chain.
module tb_fac_mul_r4;
    import fac_pkg::*;

    localparam int unsigned W = FAC_WIDTH;
    localparam int unsigned P = 2 * W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fac_mul_r4_if #(.WIDTH(W)) bus ();

    fac_mul_r4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.op_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, P'(bus.op_done), P'(1'b1));
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        bus.op_clear = 1'b1;
        bus.op_start = 1'b0;
        @(negedge clk);
        bus.op_clear = 1'b0;
        check({tag, "_clr_res"},  bus.result,      P'(0));
        check({tag, "_clr_done"}, P'(bus.op_done), P'(0));
    endtask

    // Start one product, perturb operands mid-run, then check latency, busy span and hold.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [P-1:0] exp, input int exp_lat,
                          input bit hold, input string tag);
        int n;
        int busy_n;
        @(negedge clk);
        bus.multi        = a;
        bus.multiplicand = b;
        bus.op_start     = 1'b1;
        @(negedge clk);
        if (!hold) bus.op_start = 1'b0;
        n = 0;
        busy_n = 0;
        while (!bus.op_done && n < 40) begin
            if (bus.busy) busy_n++;
            if (n == 10) begin
                bus.multi        = ~a;
                bus.multiplicand = b ^ 64'h5A5A_5A5A_5A5A_5A5A;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"},  P'(n),      P'(exp_lat));
        check({tag, "_busy"}, P'(busy_n), P'(exp_lat));
        check({tag, "_res"},  bus.result, exp);
        repeat (3) @(negedge clk);
        check({tag, "_hold_res"},  bus.result,      exp);
        check({tag, "_hold_done"}, P'(bus.op_done), P'(1'b1));
        check({tag, "_hold_busy"}, P'(bus.busy),    P'(1'b0));
    endtask

    initial begin
        logic [P-1:0] prod;
        logic [P-1:0] exp;

        reset            = 1'b1;
        bus.multi        = '0;
        bus.multiplicand = '0;
        bus.op_start     = 1'b0;
        bus.op_clear     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_res",  bus.result,      P'(0));
        check("rst_done", P'(bus.op_done), P'(0));
        check("rst_busy", P'(bus.busy),    P'(0));
        reset = 1'b0;

        do_mul(64'd5, 64'd7, P'(35), 32, 1'b0, "m5x7");
        do_clear("m5x7");

        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 32, 1'b0, "mmax");
        do_clear("mmax");

        do_mul(64'd0, 64'd9, P'(0), 0, 1'b0, "zero_a");
        do_clear("zero_a");
        do_mul(64'd9, 64'd0, P'(0), 0, 1'b0, "zero_b");
        do_clear("zero_b");

        // Start held high through DONE with operands disturbed mid-run.
        do_mul(64'd123456789, 64'd987654321, 128'd121932631112635269, 32, 1'b1, "hold");
        do_clear("hold");

        // Clear in the middle of EXEC.
        @(negedge clk);
        bus.multi = 64'd9; bus.multiplicand = 64'd11; bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        repeat (10) @(negedge clk);
        check("midclr_pre_busy", P'(bus.busy), P'(1'b1));
        bus.op_clear = 1'b1;
        @(negedge clk);
        bus.op_clear = 1'b0;
        check("midclr_busy", P'(bus.busy),    P'(0));
        check("midclr_done", P'(bus.op_done), P'(0));
        check("midclr_res",  bus.result,      P'(0));
        repeat (40) @(negedge clk);
        check("midclr_nodone", P'(bus.op_done), P'(0));
        do_mul(64'd3, 64'd4, P'(12), 32, 1'b0, "m3x4");
        do_clear("m3x4");

        // Clear and start together in IDLE: clear wins, start taken on the next edge.
        @(negedge clk);
        bus.multi = 64'd6; bus.multiplicand = 64'd7;
        bus.op_start = 1'b1; bus.op_clear = 1'b1;
        @(negedge clk);
        check("both_idle_busy", P'(bus.busy), P'(0));
        bus.op_clear = 1'b0;
        @(negedge clk);
        check("both_next_busy", P'(bus.busy), P'(1'b1));
        bus.op_start = 1'b0;
        wait_done("both");
        check("both_res", bus.result, P'(42));

        // Async reset while in DONE, then while in EXEC.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstdone_res",  bus.result,      P'(0));
        check("rstdone_done", P'(bus.op_done), P'(0));
        @(negedge clk);
        reset = 1'b0;
        bus.multi = 64'd13; bus.multiplicand = 64'd17; bus.op_start = 1'b1;
        @(negedge clk);
        bus.op_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstexec_busy", P'(bus.busy),    P'(0));
        check("rstexec_done", P'(bus.op_done), P'(0));
        check("rstexec_res",  bus.result,      P'(0));
        @(negedge clk);
        reset = 1'b0;
        bus.multi = 64'd2; bus.multiplicand = 64'd3; bus.op_start = 1'b1;
        @(negedge clk);
        check("rst_first_start", P'(bus.busy), P'(1'b1));
        bus.op_start = 1'b0;
        wait_done("rst_after");
        check("rst_after_res", bus.result, P'(6));
        do_clear("rst_after");

        // Controller-style chain 1 x 20 x 19 ... x 2.
        prod = P'(1);
        for (int i = 20; i >= 2; i--) begin
            exp = (i == 2) ? 128'h21C3_677C_82B4_0000 : prod * P'(i);
            do_mul(prod[W-1:0], W'(i), exp, 32, 1'b0, $sformatf("fact%0d", i));
            do_clear($sformatf("fact%0d", i));
            prod = exp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
